// File: rtl/program_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_pkg
// Description : Shared pc control-code bit positions, named control codes and
//               the update-source selector used by the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package program_counter_pkg;

    // Bit positions inside the 3-bit pc control code
    localparam int c_pc_set  = 0;
    localparam int c_pc_out  = 1;
    localparam int c_pc_lock = 2;

    // Control codes issued by the decoder
    localparam logic [2:0] c_pc_code_idle  = 3'b000;
    localparam logic [2:0] c_pc_code_fetch = 3'b010;
    localparam logic [2:0] c_pc_code_jmp   = 3'b011;
    localparam logic [2:0] c_pc_code_lock  = 3'b100;

    // Source of the next PC value, in priority order
    typedef enum logic [2:0] {
        PC_SEL_HOLD = 3'd0,
        PC_SEL_INT  = 3'd1,
        PC_SEL_REC  = 3'd2,
        PC_SEL_JMP  = 3'd3,
        PC_SEL_INC  = 3'd4
    } pc_sel_t;

endpackage : program_counter_pkg
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_return_stack
// Description : Small LIFO of return addresses for interrupt entry/recovery.
//               dout always presents the top entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_return_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_sp_w  = c_idx_w + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_sp_w-1:0]  r_sp;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_top_idx;

    // Write slot is sp itself; the top entry sits one below (wraps harmlessly when empty)
    assign w_wr_idx  = r_sp[c_idx_w-1:0];
    assign w_top_idx = r_sp[c_idx_w-1:0] - c_idx_w'(1);

    assign full  = (r_sp == c_sp_w'(DEPTH));
    assign empty = (r_sp == '0);
    assign dout  = r_mem[w_top_idx];

    // Push writes the entry and bumps sp; pop only drops sp (callers guard full/empty)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[w_wr_idx] <= din;
            r_sp            <= r_sp + c_sp_w'(1);
        end else if (pop) begin
            r_sp <= r_sp - c_sp_w'(1);
        end
    end

endmodule : pc_return_stack
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Fetch-address register with jump load, increment, lock,
//               interrupt vectoring and return-address recovery. Drives the
//               shared address bus through per-bit tristate buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                 ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 STACK_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        i_pc_control_code,
    input  logic [ADDR_W-1:0] i_data_bus,
    input  logic              i_interrupt,
    input  logic [ADDR_W-1:0] i_int_vector,
    input  logic              i_recover,
    output wire  [ADDR_W-1:0] o_addr_bus,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_int_ack,
    output logic              o_stack_overflow,
    output logic              o_stack_underflow
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_stack_top;
    logic              w_full;
    logic              w_empty;
    logic              w_take_int;
    logic              w_int_refused;
    logic              w_take_rec;
    logic              w_rec_refused;
    logic              w_bus_en;
    pc_sel_t           w_sel;

    // Interrupt outranks recover; a recover arriving with an interrupt is dropped silently
    assign w_take_int    = i_interrupt & ~w_full;
    assign w_int_refused = i_interrupt &  w_full;
    assign w_take_rec    = ~i_interrupt & i_recover & ~w_empty;
    assign w_rec_refused = ~i_interrupt & i_recover &  w_empty;

    // Bus is released during reset and whenever lock overrides output
    assign w_bus_en = n_rst & i_pc_control_code[c_pc_out] & ~i_pc_control_code[c_pc_lock];

    pc_return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (w_take_int),
        .pop   (w_take_rec),
        .din   (r_pc),
        .dout  (w_stack_top),
        .full  (w_full),
        .empty (w_empty)
    );

    // Priority select of the next-PC source
    always_comb begin
        w_sel = PC_SEL_HOLD;
        if (i_interrupt) begin
            w_sel = w_full ? PC_SEL_HOLD : PC_SEL_INT;
        end else if (i_recover) begin
            w_sel = w_empty ? PC_SEL_HOLD : PC_SEL_REC;
        end else if (i_pc_control_code[c_pc_lock]) begin
            w_sel = PC_SEL_HOLD;
        end else if (i_pc_control_code[c_pc_set]) begin
            w_sel = PC_SEL_JMP;
        end else if (i_pc_control_code[c_pc_out]) begin
            w_sel = PC_SEL_INC;
        end
    end

    // Next-PC mux; the increment wraps naturally at the address width
    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            PC_SEL_INT: w_pc_next = i_int_vector;
            PC_SEL_REC: w_pc_next = w_stack_top;
            PC_SEL_JMP: w_pc_next = i_data_bus;
            PC_SEL_INC: w_pc_next = r_pc + ADDR_W'(1);
            default:    w_pc_next = r_pc;
        endcase
    end

    // PC register, interrupt acknowledge and sticky stack-error flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pc              <= RESET_VECTOR;
            o_int_ack         <= 1'b0;
            o_stack_overflow  <= 1'b0;
            o_stack_underflow <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            o_int_ack <= w_take_int;
            if (w_int_refused) o_stack_overflow  <= 1'b1;
            if (w_rec_refused) o_stack_underflow <= 1'b1;
        end
    end

    assign o_pc = r_pc;

    // One tristate buffer per address bit
    generate
        for (genvar i = 0; i < ADDR_W; i++) begin : g_addr_drv
            bufif1 u_drv (o_addr_bus[i], r_pc[i], w_bus_en);
        end
    endgenerate

endmodule : program_counter
`default_nettype wire
